lut_sxx_cfg_loader: RTL and testbench
=====================================

// Module: lut_sxx_cfg_loader
// PURPOSE
//  Upstream config stage for the fracturable sXX LUT pair. Accepts a config frame as WORD_W-bit beats
//  over a valid/ready stream, stages it, then drives config_in/cen for one cycle so the LUT pair and
//  its split (fracture) bit load atomically. Runs on the fabric clock; integrator ties LUT cclk to clk.
// PARAMETERS
//  INPUTS    4                      address bits per LUT half
//  MEM_SIZE  2**INPUTS              bits per LUT half
//  CFG_W     2*MEM_SIZE+1           frame width; MSB = split bit, [2*MEM_SIZE-1:MEM_SIZE] first LUT, [MEM_SIZE-1:0] second
//  WORD_W    8                      bits per input beat
//  BEATS     (CFG_W+WORD_W-1)/WORD_W  beats per frame (5 at defaults)
// PORTS
//  clk         in   1       fabric clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       pulse: begin a frame (ignored unless IDLE)
//  abort       in   1       discard frame in progress
//  in_data     in   WORD_W  config beat
//  in_valid    in   1       beat valid
//  in_ready    out  1       loader accepts beat
//  config_out  out  CFG_W   to LUT config_in; registered, changes only on commit
//  cen         out  1       to LUT cen; one-cycle pulse with new config_out
//  busy        out  1       high in LOAD and COMMIT
//  done        out  1       one-cycle pulse, same cycle as cen
//  err         out  1       one-cycle pulse on abort of a frame
// BEHAVIOUR
//  Reset: state=IDLE; config_out=0, cen=0, in_ready=0, busy=0, done=0, err=0; staging reg and beat_cnt cleared.
//   rst mid-frame: same result; no cen issued, partial frame lost.
//  FSM IDLE -> LOAD -> COMMIT -> IDLE.
//   IDLE: start=1 -> LOAD next cycle, beat_cnt=0. in_valid ignored in IDLE.
//   LOAD: in_ready=1 (registered, high the whole state). Handshake = in_valid&in_ready.
//    Beat k written to stage[k*WORD_W +: WORD_W], LSB-first; final-beat bits above CFG_W-1 dropped.
//    beat_cnt increments per handshake; handshake on beat BEATS-1 -> COMMIT next cycle, in_ready drops same edge.
//    in_valid gaps allowed; no timeout. start in LOAD ignored.
//   COMMIT (exactly 1 cycle): config_out=stage, cen=1, done=1; then IDLE.
//  abort: in LOAD -> IDLE next cycle, err=1 one cycle, config_out untouched, no cen.
//   abort in same cycle as last-beat handshake: abort wins (no commit). abort in IDLE/COMMIT ignored.
//  start and abort same cycle in IDLE: abort ignored, frame starts.
//  Min frame latency: start@t0 -> LOAD@t1; with in_valid held, last beat @t1+BEATS-1 -> cen@t1+BEATS.
//  beat_cnt width $clog2(BEATS+1); never wraps (exits at BEATS-1).
//  Back-to-back frames: start accepted in the IDLE cycle right after COMMIT.
// STRUCTURE
//  Shared pkg lut_cfg_pkg: CFG_W/BEATS derivation, state encoding (IDLE/LOAD/COMMIT), split-bit index.
//  One sub-module natural: cfg_stage_reg (beat-indexed write into CFG_W staging reg). FSM + outputs in top.
// TESTING
//  1 Reset: rst=1 2 cycles -> all outputs 0; start during rst -> stays IDLE, in_ready=0.
//  2 Full frame, defaults: start, beats 0xA5,0x3C,0xFF,0x00,0x01 back-to-back -> cen=done=1 exactly one
//    cycle, config_out=33'h1_00FF_3CA5, split bit (bit 32)=1; cen 5 cycles after first in_ready.
//  3 Gapped valids: same beats with in_valid low 3 cycles between each -> identical config_out, one cen.
//  4 Abort after beat 2 -> err=1 one cycle, cen never high, config_out keeps prior 33'h1_00FF_3CA5.
//  5 Abort coincident with last handshake -> err pulse, no cen; then full frame of zeros -> config_out=0.
//  6 start pulsed mid-LOAD and in_valid in IDLE -> no effect: beat count and config_out match frame 2.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the sXX LUT-pair config path: frame geometry,
// beat counting and loader state encoding.
package lut_cfg_pkg;

  localparam int DEF_INPUTS = 4;
  localparam int DEF_WORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } ld_state_e;

  function automatic int mem_size(input int inputs);
    return 1 << inputs;
  endfunction

  // Two LUT halves plus the fracture (split) bit on top.
  function automatic int cfg_width(input int inputs);
    return 2 * mem_size(inputs) + 1;
  endfunction

  function automatic int split_index(input int inputs);
    return 2 * mem_size(inputs);
  endfunction

  function automatic int beat_count(input int cfg_w, input int word_w);
    return (cfg_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_stage_reg.sv
// Beat-indexed staging register: each accepted beat lands in its own
// WORD_W slice, LSB-first; final-beat bits beyond the frame are dropped.
module cfg_stage_reg
  import lut_cfg_pkg::*;
#(
  parameter int CFG_W  = cfg_width(DEF_INPUTS),
  parameter int WORD_W = DEF_WORD_W,
  parameter int BEATS  = beat_count(CFG_W, WORD_W),
  parameter int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic [CFG_W-1:0]  stage,
  output logic [CFG_W-1:0]  stage_next
);

  logic [CFG_W-1:0] stage_q;
  logic [CFG_W-1:0] stage_d;
  logic [BEATS-1:0] beat_hit;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      localparam int LO = gi * WORD_W;
      localparam int W  = ((CFG_W - LO) < WORD_W) ? (CFG_W - LO) : WORD_W;

      assign beat_hit[gi] = wr_en && (beat_idx == CNT_W'(gi));
      assign stage_d[LO +: W] = beat_hit[gi] ? wr_data[W-1:0] : stage_q[LO +: W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage      = stage_q;
  assign stage_next = stage_d;

endmodule

// File: rtl/lut_sxx_cfg_loader.sv
// Config loader for the fracturable sXX LUT pair: collects a frame over a
// valid/ready beat stream, then presents it with a one-cycle cen pulse.
module lut_sxx_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS = DEF_INPUTS,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [cfg_width(INPUTS)-1:0]  config_out,
  output logic                          cen,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int CFG_W = cfg_width(INPUTS);
  localparam int BEATS = beat_count(CFG_W, WORD_W);
  localparam int CNT_W = $clog2(BEATS + 1);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CFG_W-1:0] config_out_q, config_out_d;
  logic             in_ready_q, in_ready_d;
  logic             cen_q, cen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             handshake;
  logic             last_beat;
  logic             stage_wr;
  logic [CFG_W-1:0] stage;
  logic [CFG_W-1:0] stage_next;

  assign handshake = in_valid && in_ready_q;
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  cfg_stage_reg #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .CNT_W  (CNT_W)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (stage_wr),
    .beat_idx   (beat_cnt_q),
    .wr_data    (in_data),
    .stage      (stage),
    .stage_next (stage_next)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    config_out_d = config_out_q;
    in_ready_d   = 1'b0;
    cen_d        = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    stage_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          beat_cnt_d = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      ST_LOAD: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
        // abort outranks a coincident final handshake: nothing is committed
        if (abort) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
        end else if (handshake) begin
          stage_wr   = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d      = ST_COMMIT;
            in_ready_d   = 1'b0;
            config_out_d = stage_next;
            cen_d        = 1'b1;
            done_d       = 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      config_out_q <= '0;
      in_ready_q   <= 1'b0;
      cen_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      config_out_q <= config_out_d;
      in_ready_q   <= in_ready_d;
      cen_q        <= cen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign config_out = config_out_q;
  assign cen        = cen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lut_sxx_cfg_loader.sv
// Directed bench for lut_sxx_cfg_loader at default geometry (33-bit frame,
// five 8-bit beats); outputs are sampled on the falling edge.
module tb_lut_sxx_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] config_out;
  logic        cen;
  logic        busy;
  logic        done;
  logic        err;

  int checks  = 0;
  int errors  = 0;
  int ncyc    = 0;
  int cen_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  localparam logic [39:0] FRAME_A = 40'h01_00_FF_3C_A5;
  localparam logic [32:0] CFG_A   = 33'h1_00FF_3CA5;

  lut_sxx_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .config_out (config_out),
    .cen        (cen),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Pulse counters: each high cycle of cen/done/err adds one.
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (rst === 1'b0) begin
      if (cen === 1'b1)  cen_cnt  <= cen_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (err === 1'b1)  err_cnt  <= err_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 abort in the cycle after beat 2, 2 abort with last beat,
  //       3 stray start pulse alongside beat 1
  task automatic do_frame(input logic [39:0] data, input int gap, input int mode,
                          output int lat);
    int t_rdy;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_rdy = ncyc;
    chk("in_ready_load", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      in_data  = data[k*8 +: 8];
      in_valid = 1'b1;
      if (mode == 2 && k == 4) abort = 1'b1;
      if (mode == 3 && k == 1) start = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      start    = 1'b0;
      if (mode == 1 && k == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      if (k < 4) repeat (gap) @(negedge clk);
    end
    lat = ncyc - t_rdy;
  endtask

  initial begin
    int lat;
    int c0, d0, e0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // 1: reset, with start asserted during reset
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_config_out", {31'd0, config_out}, 64'd0);
    chk("rst_cen",      {63'd0, cen},      64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy",     {63'd0, busy},     64'd0);
    chk("rst_done",     {63'd0, done},     64'd0);
    chk("rst_err",      {63'd0, err},      64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("post_rst_busy",     {63'd0, busy},     64'd0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_err", {63'd0, err}, 64'd0);
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_valid_in_ready", {63'd0, in_ready}, 64'd0);

    // 2: full frame, back-to-back beats
    c0 = cen_cnt; d0 = done_cnt;
    do_frame(FRAME_A, 0, 0, lat);
    chk("f2_cen",        {63'd0, cen},  64'd1);
    chk("f2_done",       {63'd0, done}, 64'd1);
    chk("f2_busy",       {63'd0, busy}, 64'd1);
    chk("f2_config_out", {31'd0, config_out}, {31'd0, CFG_A});
    chk("f2_split_bit",  {63'd0, config_out[32]}, 64'd1);
    chk("f2_latency",    64'(lat), 64'd5);
    @(negedge clk);
    chk("f2_cen_drop",   {63'd0, cen},  64'd0);
    chk("f2_done_drop",  {63'd0, done}, 64'd0);
    chk("f2_busy_drop",  {63'd0, busy}, 64'd0);
    chk("f2_cen_pulses",  64'(cen_cnt - c0),  64'd1);
    chk("f2_done_pulses", 64'(done_cnt - d0), 64'd1);

    // 3: gapped valids
    c0 = cen_cnt;
    do_frame(FRAME_A, 3, 0, lat);
    chk("f3_cen",        {63'd0, cen}, 64'd1);
    chk("f3_config_out", {31'd0, config_out}, {31'd0, CFG_A});
    chk("f3_latency",    64'(lat), 64'd17);
    @(negedge clk);
    chk("f3_cen_pulses", 64'(cen_cnt - c0), 64'd1);

    // 4: abort after beat 2
    c0 = cen_cnt; e0 = err_cnt;
    do_frame(40'h55_66_77_88_99, 0, 1, lat);
    chk("f4_err",       {63'd0, err},      64'd1);
    chk("f4_in_ready",  {63'd0, in_ready}, 64'd0);
    chk("f4_busy",      {63'd0, busy},     64'd0);
    @(negedge clk);
    chk("f4_err_drop",  {63'd0, err}, 64'd0);
    chk("f4_config_out", {31'd0, config_out}, {31'd0, CFG_A});
    chk("f4_cen_pulses", 64'(cen_cnt - c0), 64'd0);
    chk("f4_err_pulses", 64'(err_cnt - e0), 64'd1);

    // 5: abort coincident with the last handshake, then an all-zero frame
    c0 = cen_cnt; e0 = err_cnt;
    do_frame(40'hFF_FF_FF_FF_FF, 0, 2, lat);
    chk("f5_err",        {63'd0, err}, 64'd1);
    chk("f5_cen",        {63'd0, cen}, 64'd0);
    chk("f5_config_out", {31'd0, config_out}, {31'd0, CFG_A});
    @(negedge clk);
    chk("f5_cen_pulses", 64'(cen_cnt - c0), 64'd0);
    chk("f5_err_pulses", 64'(err_cnt - e0), 64'd1);
    do_frame(40'h00_00_00_00_00, 0, 0, lat);
    chk("f5z_cen",        {63'd0, cen}, 64'd1);
    chk("f5z_config_out", {31'd0, config_out}, 64'd0);
    @(negedge clk);

    // 6: in_valid while idle and start pulsed mid-LOAD have no effect
    c0 = cen_cnt; e0 = err_cnt;
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) @(negedge clk);
    chk("f6_idle_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    do_frame(FRAME_A, 0, 3, lat);
    chk("f6_cen",        {63'd0, cen}, 64'd1);
    chk("f6_latency",    64'(lat), 64'd5);
    chk("f6_config_out", {31'd0, config_out}, {31'd0, CFG_A});
    @(negedge clk);
    chk("f6_cen_pulses", 64'(cen_cnt - c0), 64'd1);
    chk("f6_err_pulses", 64'(err_cnt - e0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
